// File: rtl/regfile_dump_ctrl.sv
// rtl/regfile_dump_ctrl.sv - walks the register file read port and streams {addr, data} beats
// Optional running XOR checksum output enabled by REGFILE_DUMP_CHECKSUM_EN.
module regfile_dump_ctrl #(
    parameter int NREGS  = 32,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rf_readaddr,
    input  logic [DATA_W-1:0] rf_readdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
`ifdef REGFILE_DUMP_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] out_sum
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_SEND,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREGS - 1);
    localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_index;
    logic [ADDR_W-1:0]   r_out_addr;
    logic [DATA_W-1:0]   r_out_data;
    logic                r_out_valid;
    logic                r_out_last;
    logic                w_is_last;
    logic                w_handshake;
    logic                w_start_accept;

    assign w_is_last      = (r_index == LAST_IDX);
    assign w_handshake    = (r_state == S_SEND) && r_out_valid && out_ready;
    assign w_start_accept = (r_state == S_IDLE) && start;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (start) w_next = S_FETCH;
            S_FETCH: w_next = S_SEND;
            S_SEND: begin
                if (w_handshake) begin
                    w_next = w_is_last ? S_DONE : S_FETCH;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Beat registers stay frozen across SEND so a stalled sink sees a stable beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_index     <= '0;
            r_out_addr  <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) r_index <= '0;
                end
                S_FETCH: begin
                    r_out_data  <= rf_readdata;
                    r_out_addr  <= r_index;
                    r_out_valid <= 1'b1;
                    r_out_last  <= w_is_last;
                end
                S_SEND: begin
                    if (w_handshake) begin
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                        if (!w_is_last) r_index <= r_index + IDX_ONE;
                    end
                end
                S_DONE: begin
                    r_index <= '0;
                end
                default: begin
                    r_index <= '0;
                end
            endcase
        end
    end

`ifdef REGFILE_DUMP_CHECKSUM_EN
    logic [DATA_W-1:0] r_sum;

    always_ff @(posedge clk) begin
        if (reset || w_start_accept) begin
            r_sum <= '0;
        end else if (w_handshake) begin
            r_sum <= r_sum ^ r_out_data;
        end
    end

    assign out_sum = r_sum;
`endif

    // Index returns to 0 on leaving DONE, so the read address is 0 whenever idle.
    assign rf_readaddr = r_index;
    assign busy        = (r_state == S_FETCH) || (r_state == S_SEND);
    assign done        = (r_state == S_DONE);
    assign out_valid   = r_out_valid;
    assign out_addr    = r_out_addr;
    assign out_data    = r_out_data;
    assign out_last    = r_out_last;

endmodule

// File: tb/tb_regfile_dump_ctrl.sv
// tb/tb_regfile_dump_ctrl.sv - scoreboard bench for regfile_dump_ctrl
module tb_regfile_dump_ctrl;

    localparam int NREGS  = 32;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    logic              clk;
    logic              reset;
    logic              start;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] rf_readaddr;
    logic [DATA_W-1:0] rf_readdata;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_addr;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
`ifdef REGFILE_DUMP_CHECKSUM_EN
    logic [DATA_W-1:0] out_sum;
    logic [DATA_W-1:0] sum_at_done;
`endif

    logic [DATA_W-1:0] regs [NREGS];
    assign rf_readdata = regs[rf_readaddr];

    regfile_dump_ctrl #(.NREGS(NREGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .rf_readaddr(rf_readaddr),
        .rf_readdata(rf_readdata),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_addr   (out_addr),
        .out_data   (out_data),
        .out_last   (out_last)
`ifdef REGFILE_DUMP_CHECKSUM_EN
        ,
        .out_sum    (out_sum)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int e        = 0;
    int e0       = 0;
    int n_beats  = 0;
    int n_done   = 0;
    int last_hs_e = -1;
    int done_e    = -1;
    logic [ADDR_W+DATA_W:0] sb_q [$];

    always @(posedge clk) e <= e + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: each handshake pops the oldest expected beat.
    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid && out_ready) begin
                chk("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
                if (sb_q.size() != 0) begin
                    logic [ADDR_W+DATA_W:0] exp_beat;
                    exp_beat = sb_q.pop_front();
                    chk("beat_addr", 64'(out_addr), 64'(exp_beat[ADDR_W+DATA_W:DATA_W+1]));
                    chk("beat_data", 64'(out_data), 64'(exp_beat[DATA_W:1]));
                    chk("beat_last", 64'(out_last), 64'(exp_beat[0]));
                end
                n_beats++;
                if (out_last) last_hs_e = e + 1;
            end
            if (done) begin
                n_done++;
                done_e = e;
`ifdef REGFILE_DUMP_CHECKSUM_EN
                sum_at_done = out_sum;
`endif
            end
        end
    end

    task automatic kick();
        for (int i = 0; i < NREGS; i++) begin
            logic [ADDR_W-1:0] a;
            a = ADDR_W'(i);
            sb_q.push_back({a, regs[i], (i == NREGS - 1)});
        end
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        e0 = e;
    endtask

    task automatic wait_valid_addr(input logic [ADDR_W-1:0] a);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(posedge clk);
            #1;
            if (out_valid && out_addr == a) found = 1'b1;
        end
        chk("wait_beat_addr", 64'(found), 64'd1);
    endtask

    task automatic wait_done(input int target);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(posedge clk);
            #1;
            if (n_done >= target) found = 1'b1;
        end
        chk("wait_done", 64'(found), 64'd1);
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < NREGS; i++) regs[i] = DATA_W'(i) * 32'h01010101;

        // Reset held with start high.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_last", 64'(out_last), 64'd0);
        chk("rst_addr", 64'(out_addr), 64'd0);
        chk("rst_data", 64'(out_data), 64'd0);
        chk("rst_rdaddr", 64'(rf_readaddr), 64'd0);
        reset = 1'b0;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("idle_no_beats", 64'(n_beats), 64'd0);
        chk("idle_busy", 64'(busy), 64'd0);

        // Full dump at full rate, with latency checks.
        kick();
        chk("busy_after_start", 64'(busy), 64'd1);
        wait_done(1);
        repeat (2) @(posedge clk);
        #1;
        chk("full_beats", 64'(n_beats), 64'd32);
        chk("last_hs_edge", 64'(last_hs_e - e0), 64'd64);
        chk("done_cycle", 64'(done_e - e0), 64'd64);
        chk("full_sb_empty", 64'(sb_q.size()), 64'd0);
        chk("full_busy_end", 64'(busy), 64'd0);
        chk("idle_rdaddr", 64'(rf_readaddr), 64'd0);

        // Backpressure on beat 3.
        n_beats = 0;
        kick();
        wait_valid_addr(ADDR_W'(3));
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("stall_valid", 64'(out_valid), 64'd1);
            chk("stall_addr", 64'(out_addr), 64'd3);
            chk("stall_data", 64'(out_data), 64'h03030303);
        end
        out_ready = 1'b1;
        wait_done(2);
        repeat (2) @(posedge clk);
        #1;
        chk("stall_beats", 64'(n_beats), 64'd32);
        chk("stall_done_cnt", 64'(n_done), 64'd2);

        // Start while busy must be ignored.
        n_beats = 0;
        kick();
        wait_valid_addr(ADDR_W'(10));
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(3);
        repeat (40) @(posedge clk);
        #1;
        chk("restart_beats", 64'(n_beats), 64'd32);
        chk("restart_done_cnt", 64'(n_done), 64'd3);
        chk("restart_valid", 64'(out_valid), 64'd0);

        // Reset wins over a handshake on beat 10.
        n_beats = 0;
        kick();
        wait_valid_addr(ADDR_W'(10));
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_valid", 64'(out_valid), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_addr", 64'(out_addr), 64'd0);
        reset = 1'b0;
        sb_q.delete();
        repeat (70) @(posedge clk);
        #1;
        chk("midrst_no_done", 64'(n_done), 64'd3);
        chk("midrst_beats", 64'(n_beats), 64'd10);
        n_beats = 0;
        kick();
        wait_done(4);
        repeat (2) @(posedge clk);
        #1;
        chk("after_rst_beats", 64'(n_beats), 64'd32);

`ifdef REGFILE_DUMP_CHECKSUM_EN
        for (int i = 0; i < NREGS; i++) regs[i] = '0;
        regs[5] = 32'hA5A5A5A5;
        regs[7] = 32'h0F0F0F0F;
        kick();
        chk("sum_cleared", 64'(out_sum), 64'd0);
        wait_done(5);
        chk("sum_at_done", 64'(sum_at_done), 64'hAAAAAAAA);
        repeat (3) @(posedge clk);
        #1;
        chk("sum_held", 64'(out_sum), 64'hAAAAAAAA);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
